// File: rtl/data_memory_unit.sv
// data_memory_unit
//   Data-memory stage for the single-cycle MIPS core. Combinational
//   (zero-latency) loads, word stores committed on the rising clock edge,
//   a sticky record of the first faulting access, and saturating load/store
//   counters for debug.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        synchronous, active-high reset (memory array is not cleared)
//   addr       byte address from the core ALU
//   wr_data    store data (core Read2)
//   mem_read   load strobe
//   mem_write  store strobe
//   err_clr    clears the sticky fault record (a simultaneous new fault wins)
//   rd_data    load data to the core (MD_out); 0 unless a valid load
//   err_valid  sticky fault flag
//   err_cause  {out_of_range, misaligned} of the captured fault
//   err_addr   address of the captured fault
//   rd_count   accepted loads, saturating
//   wr_count   accepted stores, saturating
//   mmio_out   debug output register
//
// Optional feature
//   DATA_MEMORY_UNIT_MMIO_EN: when defined, addr == MMIO_ADDR is always a
//   valid access that reads/writes mmio_out instead of the array. When not
//   defined, mmio_out is tied to zero and MMIO_ADDR decodes like any other
//   address.
module data_memory_unit #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned CNT_W       = 16,
  parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_FFF0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      wr_data,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             err_clr,
  output logic [31:0]      rd_data,
  output logic             err_valid,
  output logic [1:0]       err_cause,
  output logic [31:0]      err_addr,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  output logic [31:0]      mmio_out
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  // Byte span of the array, one bit wider so large depths cannot overflow.
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

`ifdef DATA_MEMORY_UNIT_MMIO_EN
  localparam bit MMIO_ON = 1'b1;
`else
  localparam bit MMIO_ON = 1'b0;
`endif

  // Storage: zero at time 0, untouched by rst.
  logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

  logic [31:0]      off;
  logic             in_range;
  logic             aligned;
  logic             is_mmio;
  logic             valid;
  logic             rd_acc;
  logic             wr_acc;
  logic             fault;
  logic [AW-1:0]    idx;

  logic             err_valid_q, err_valid_d;
  logic [1:0]       err_cause_q, err_cause_d;
  logic [31:0]      err_addr_q,  err_addr_d;
  logic [CNT_W-1:0] rd_count_q,  rd_count_d;
  logic [CNT_W-1:0] wr_count_q,  wr_count_d;
  logic [31:0]      mmio_q,      mmio_d;

  // Address decode
  always_comb begin
    off      = addr - ADDR_BASE;
    in_range = (addr >= ADDR_BASE) && ({1'b0, off} < SPAN);
    aligned  = (addr[1:0] == 2'b00);
    idx      = off[AW+1:2];
    is_mmio  = MMIO_ON && (addr == MMIO_ADDR);
    valid    = is_mmio || (in_range && aligned);
    rd_acc   = mem_read  && valid;
    wr_acc   = mem_write && valid;
    fault    = (mem_read || mem_write) && !valid;
  end

  // Load path: the array is read before the edge commits any store, so a
  // same-cycle read+write returns the old word.
  always_comb begin
    rd_data = '0;
    if (rd_acc) begin
      if (is_mmio) rd_data = mmio_q;
      else         rd_data = mem_q[idx];
    end
  end

  // Next-state for fault record, counters and MMIO register
  always_comb begin
    err_valid_d = err_valid_q;
    err_cause_d = err_cause_q;
    err_addr_d  = err_addr_q;
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    mmio_d      = mmio_q;

    // A new fault is captured when no record is held, or when the record
    // is being cleared in the same cycle (fault beats clear).
    if (fault && (!err_valid_q || err_clr)) begin
      err_valid_d = 1'b1;
      err_cause_d = {!in_range, !aligned};
      err_addr_d  = addr;
    end else if (err_clr) begin
      err_valid_d = 1'b0;
      err_cause_d = '0;
      err_addr_d  = '0;
    end

    if (rd_acc && (rd_count_q != '1)) rd_count_d = rd_count_q + CNT_W'(1);
    if (wr_acc && (wr_count_q != '1)) wr_count_d = wr_count_q + CNT_W'(1);

    if (wr_acc && is_mmio) mmio_d = wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid_q <= 1'b0;
      err_cause_q <= '0;
      err_addr_q  <= '0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      mmio_q      <= '0;
    end else begin
      err_valid_q <= err_valid_d;
      err_cause_q <= err_cause_d;
      err_addr_q  <= err_addr_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      mmio_q      <= mmio_d;
    end
  end

  // Array write port; the MMIO address never reaches the array.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc && !is_mmio) mem_q[idx] <= wr_data;
  end

  assign err_valid = err_valid_q;
  assign err_cause = err_cause_q;
  assign err_addr  = err_addr_q;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;

`ifdef DATA_MEMORY_UNIT_MMIO_EN
  assign mmio_out = mmio_q;
`else
  assign mmio_out = 32'h0;
`endif

endmodule

// File: tb/tb_data_memory_unit.sv
// Self-checking bench for data_memory_unit (CNT_W = 4 so saturation is
// reachable quickly). Expected values are pushed to a scoreboard queue when
// stimulus is driven and popped when the DUT output is sampled.
module tb_data_memory_unit;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   addr;
  logic [31:0]   wr_data;
  logic          mem_read;
  logic          mem_write;
  logic          err_clr;
  logic [31:0]   rd_data;
  logic          err_valid;
  logic [1:0]    err_cause;
  logic [31:0]   err_addr;
  logic [CW-1:0] rd_count;
  logic [CW-1:0] wr_count;
  logic [31:0]   mmio_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] e;

  data_memory_unit #(
    .DEPTH_WORDS(1024),
    .ADDR_BASE  (32'h0000_0000),
    .CNT_W      (CW),
    .MMIO_ADDR  (32'hFFFF_FFF0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wr_data  (wr_data),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .err_clr  (err_clr),
    .rd_data  (rd_data),
    .err_valid(err_valid),
    .err_cause(err_cause),
    .err_addr (err_addr),
    .rd_count (rd_count),
    .wr_count (wr_count),
    .mmio_out (mmio_out)
  );

  always #5 clk = ~clk;

  // Drive happens 1 ns after a rising edge; combinational samples 3 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_read = 1'b0; mem_write = 1'b0; err_clr = 1'b0;
    addr = '0; wr_data = '0;
  endtask

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) return 32'hxxxx_xxxx;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    idle(); rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = pop_exp(); total++;
    if ({31'h0, err_valid} !== e) begin bad++; $display("FAIL rst_err_valid got=%h exp=%h", err_valid, e); end
    e = pop_exp(); total++;
    if ({30'h0, err_cause} !== e) begin bad++; $display("FAIL rst_err_cause got=%h exp=%h", err_cause, e); end
    e = pop_exp(); total++;
    if (err_addr !== e) begin bad++; $display("FAIL rst_err_addr got=%h exp=%h", err_addr, e); end
    e = pop_exp(); total++;
    if ({28'h0, rd_count} !== e) begin bad++; $display("FAIL rst_rd_count got=%h exp=%h", rd_count, e); end
    e = pop_exp(); total++;
    if ({28'h0, wr_count} !== e) begin bad++; $display("FAIL rst_wr_count got=%h exp=%h", wr_count, e); end
    e = pop_exp(); total++;
    if (mmio_out !== e) begin bad++; $display("FAIL rst_mmio_out got=%h exp=%h", mmio_out, e); end
  endtask

  task automatic test_store_load();
    // store only: rd_data stays 0
    addr = 32'h10; wr_data = 32'hDEADBEEF; mem_write = 1'b1;
    exp_q.push_back(32'h0);
    #3; e = pop_exp(); total++;
    if (rd_data !== e) begin bad++; $display("FAIL st_rd_zero got=%h exp=%h", rd_data, e); end
    tick(); idle();
    addr = 32'h10; mem_read = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    #3; e = pop_exp(); total++;
    if (rd_data !== e) begin bad++; $display("FAIL ld_0x10 got=%h exp=%h", rd_data, e); end
    tick(); idle();
    exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    e = pop_exp(); total++;
    if ({28'h0, wr_count} !== e) begin bad++; $display("FAIL st_wr_count got=%h exp=%h", wr_count, e); end
    e = pop_exp(); total++;
    if ({28'h0, rd_count} !== e) begin bad++; $display("FAIL ld_rd_count got=%h exp=%h", rd_count, e); end
    // highest word of the array
    addr = 32'hFFC; wr_data = 32'h0BAD_F00D; mem_write = 1'b1;
    tick(); idle();
    addr = 32'hFFC; mem_read = 1'b1;
    exp_q.push_back(32'h0BAD_F00D);
    #3; e = pop_exp(); total++;
    if (rd_data !== e) begin bad++; $display("FAIL ld_last_word got=%h exp=%h", rd_data, e); end
    tick(); idle();
  endtask

  task automatic test_read_before_write();
    addr = 32'h20; wr_data = 32'h1111_1111; mem_write = 1'b1;
    tick(); idle();
    addr = 32'h20; wr_data = 32'h2222_2222; mem_write = 1'b1; mem_read = 1'b1;
    exp_q.push_back(32'h1111_1111);
    #3; e = pop_exp(); total++;
    if (rd_data !== e) begin bad++; $display("FAIL rbw_old got=%h exp=%h", rd_data, e); end
    tick(); idle();
    addr = 32'h20; mem_read = 1'b1;
    exp_q.push_back(32'h2222_2222);
    #3; e = pop_exp(); total++;
    if (rd_data !== e) begin bad++; $display("FAIL rbw_new got=%h exp=%h", rd_data, e); end
    tick(); idle();
    // stores: 0x10, 0xFFC, 0x20, 0x20 ; loads: 0x10, 0xFFC, 0x20, 0x20
    exp_q.push_back(32'd4); exp_q.push_back(32'd4);
    e = pop_exp(); total++;
    if ({28'h0, wr_count} !== e) begin bad++; $display("FAIL rbw_wr_count got=%h exp=%h", wr_count, e); end
    e = pop_exp(); total++;
    if ({28'h0, rd_count} !== e) begin bad++; $display("FAIL rbw_rd_count got=%h exp=%h", rd_count, e); end
  endtask

  task automatic test_fault();
    addr = 32'h13; wr_data = 32'hAAAA_0000; mem_write = 1'b1;
    tick(); idle();
    exp_q.push_back(32'h1); exp_q.push_back(32'h1); exp_q.push_back(32'h13);
    e = pop_exp(); total++;
    if ({31'h0, err_valid} !== e) begin bad++; $display("FAIL mis_err_valid got=%h exp=%h", err_valid, e); end
    e = pop_exp(); total++;
    if ({30'h0, err_cause} !== e) begin bad++; $display("FAIL mis_err_cause got=%h exp=%h", err_cause, e); end
    e = pop_exp(); total++;
    if (err_addr !== e) begin bad++; $display("FAIL mis_err_addr got=%h exp=%h", err_addr, e); end
    addr = 32'h10; mem_read = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    #3; e = pop_exp(); total++;
    if (rd_data !== e) begin bad++; $display("FAIL mis_mem_kept got=%h exp=%h", rd_data, e); end
    tick(); idle();
    addr = 32'h5000; mem_read = 1'b1;
    exp_q.push_back(32'h0);
    #3; e = pop_exp(); total++;
    if (rd_data !== e) begin bad++; $display("FAIL oor_rd_zero got=%h exp=%h", rd_data, e); end
    tick(); idle();
    exp_q.push_back(32'h1); exp_q.push_back(32'h13); exp_q.push_back(32'd5); exp_q.push_back(32'd4);
    e = pop_exp(); total++;
    if ({30'h0, err_cause} !== e) begin bad++; $display("FAIL sticky_cause got=%h exp=%h", err_cause, e); end
    e = pop_exp(); total++;
    if (err_addr !== e) begin bad++; $display("FAIL sticky_addr got=%h exp=%h", err_addr, e); end
    e = pop_exp(); total++;
    if ({28'h0, rd_count} !== e) begin bad++; $display("FAIL fault_rd_count got=%h exp=%h", rd_count, e); end
    e = pop_exp(); total++;
    if ({28'h0, wr_count} !== e) begin bad++; $display("FAIL fault_wr_count got=%h exp=%h", wr_count, e); end
  endtask

  task automatic test_clear_race();
    addr = 32'h1002; mem_read = 1'b1; err_clr = 1'b1;
    tick(); idle();
    exp_q.push_back(32'h1); exp_q.push_back(32'h3); exp_q.push_back(32'h1002);
    e = pop_exp(); total++;
    if ({31'h0, err_valid} !== e) begin bad++; $display("FAIL race_err_valid got=%h exp=%h", err_valid, e); end
    e = pop_exp(); total++;
    if ({30'h0, err_cause} !== e) begin bad++; $display("FAIL race_err_cause got=%h exp=%h", err_cause, e); end
    e = pop_exp(); total++;
    if (err_addr !== e) begin bad++; $display("FAIL race_err_addr got=%h exp=%h", err_addr, e); end
    err_clr = 1'b1;
    tick(); idle();
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = pop_exp(); total++;
    if ({31'h0, err_valid} !== e) begin bad++; $display("FAIL clr_err_valid got=%h exp=%h", err_valid, e); end
    e = pop_exp(); total++;
    if ({30'h0, err_cause} !== e) begin bad++; $display("FAIL clr_err_cause got=%h exp=%h", err_cause, e); end
    e = pop_exp(); total++;
    if (err_addr !== e) begin bad++; $display("FAIL clr_err_addr got=%h exp=%h", err_addr, e); end
    // first word past the array faults as out-of-range only
    addr = 32'h1000; mem_write = 1'b1; wr_data = 32'h1234_5678;
    tick(); idle();
    exp_q.push_back(32'h2);
    e = pop_exp(); total++;
    if ({30'h0, err_cause} !== e) begin bad++; $display("FAIL edge_err_cause got=%h exp=%h", err_cause, e); end
    err_clr = 1'b1;
    tick(); idle();
  endtask

  task automatic test_saturation();
    int unsigned mdl_rd;
    int unsigned mdl_wr;
    mdl_rd = rd_count;
    mdl_rd = 5; // loads accepted so far
    mdl_wr = 4;
    for (int i = 0; i < 20; i++) begin
      addr = 32'h20; mem_read = 1'b1;
      if (mdl_rd < 15) mdl_rd++;
      tick();
    end
    idle();
    exp_q.push_back(mdl_rd);
    e = pop_exp(); total++;
    if ({28'h0, rd_count} !== e) begin bad++; $display("FAIL rd_count_sat got=%h exp=%h", rd_count, e); end
    addr = 32'h30; wr_data = 32'h7777_7777; mem_write = 1'b1;
    tick();
    if (mdl_wr < 15) mdl_wr++;
    for (int i = 0; i < 16; i++) begin
      addr = 32'h40; wr_data = i; mem_write = 1'b1;
      if (mdl_wr < 15) mdl_wr++;
      tick();
    end
    idle();
    exp_q.push_back(mdl_wr);
    e = pop_exp(); total++;
    if ({28'h0, wr_count} !== e) begin bad++; $display("FAIL wr_count_sat got=%h exp=%h", wr_count, e); end
    // reset while a store is requested: the store must not land
    rst = 1'b1; addr = 32'h30; wr_data = 32'h9999_9999; mem_write = 1'b1;
    tick(); idle(); rst = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = pop_exp(); total++;
    if ({28'h0, rd_count} !== e) begin bad++; $display("FAIL rst_mid_rd_count got=%h exp=%h", rd_count, e); end
    e = pop_exp(); total++;
    if ({28'h0, wr_count} !== e) begin bad++; $display("FAIL rst_mid_wr_count got=%h exp=%h", wr_count, e); end
    addr = 32'h10; mem_read = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    #3; e = pop_exp(); total++;
    if (rd_data !== e) begin bad++; $display("FAIL keep_0x10 got=%h exp=%h", rd_data, e); end
    tick(); idle();
    addr = 32'h30; mem_read = 1'b1;
    exp_q.push_back(32'h7777_7777);
    #3; e = pop_exp(); total++;
    if (rd_data !== e) begin bad++; $display("FAIL keep_0x30 got=%h exp=%h", rd_data, e); end
    tick(); idle();
    addr = 32'h40; mem_read = 1'b1;
    exp_q.push_back(32'd15);
    #3; e = pop_exp(); total++;
    if (rd_data !== e) begin bad++; $display("FAIL keep_0x40 got=%h exp=%h", rd_data, e); end
    tick(); idle();
  endtask

  task automatic test_mmio();
    addr = 32'hFFFF_FFF0; wr_data = 32'h0000_CAFE; mem_write = 1'b1;
    tick(); idle();
`ifdef DATA_MEMORY_UNIT_MMIO_EN
    exp_q.push_back(32'h0000_CAFE); exp_q.push_back(32'h0); exp_q.push_back(32'd1);
`else
    exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'd0);
`endif
    e = pop_exp(); total++;
    if (mmio_out !== e) begin bad++; $display("FAIL mmio_out got=%h exp=%h", mmio_out, e); end
    e = pop_exp(); total++;
    if ({31'h0, err_valid} !== e) begin bad++; $display("FAIL mmio_err_valid got=%h exp=%h", err_valid, e); end
    e = pop_exp(); total++;
    if ({28'h0, wr_count} !== e) begin bad++; $display("FAIL mmio_wr_count got=%h exp=%h", wr_count, e); end
    addr = 32'hFFFF_FFF0; mem_read = 1'b1;
`ifdef DATA_MEMORY_UNIT_MMIO_EN
    exp_q.push_back(32'h0000_CAFE); exp_q.push_back(32'h0);
`else
    exp_q.push_back(32'h0); exp_q.push_back(32'h2);
`endif
    #3; e = pop_exp(); total++;
    if (rd_data !== e) begin bad++; $display("FAIL mmio_load got=%h exp=%h", rd_data, e); end
    e = pop_exp(); total++;
    if ({30'h0, err_cause} !== e) begin bad++; $display("FAIL mmio_err_cause got=%h exp=%h", err_cause, e); end
    tick(); idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    test_reset();
    test_store_load();
    test_read_before_write();
    test_fault();
    test_clear_race();
    test_saturation();
    test_mmio();
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
